// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared FSM state, ALU op encoding and sizing constants for mul_seq
package mul_seq_pkg;
    localparam int OPW = 16;
    localparam logic [4:0] CNT_LAST = 5'd15;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {ALU_ADD, ALU_SUB} alu_op_t;
endpackage

// File: rtl/mul_seq_alu.sv
// mul_seq_alu: OPW-bit add/sub ALU with carry, zero, negative and overflow flags
module mul_seq_alu
    import mul_seq_pkg::*;
(
    input  alu_op_t        op,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] y,
    output logic           c,
    output logic           z,
    output logic           n,
    output logic           v
);
    logic [OPW:0] r;
    assign r = (op == ALU_ADD) ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
    assign y = r[OPW-1:0];
    assign c = r[OPW];
    assign z = ~|y;
    assign n = y[OPW-1];
    assign v = (op == ALU_ADD) ? (a[OPW-1] == b[OPW-1]) && (y[OPW-1] != a[OPW-1])
                               : (a[OPW-1] != b[OPW-1]) && (y[OPW-1] != a[OPW-1]);
endmodule

// File: rtl/mul_seq.sv
// mul_seq: 16x16 unsigned shift-add multiplier; MUL_SEQ_EARLY_EXIT_EN stops once the multiplier runs out of set bits
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [2*OPW-1:0] p,
    output logic             hi_nz
);
    state_t           state_q, state_d;
    logic [OPW-1:0]   mcand_q, mcand_d, mult_q, mult_d;
    logic [OPW-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [2*OPW-1:0] p_q, p_d, acc_nxt, p_fin;
    logic             hi_nz_q, hi_nz_d, last;
    logic [OPW-1:0]   add_b, add_y;
    logic             add_c, alu_z_unused, alu_n_unused, alu_v_unused;

    assign add_b = mult_q[0] ? mcand_q : '0;

    mul_seq_alu u_alu (
        .op (ALU_ADD),
        .a  (acc_hi_q),
        .b  (add_b),
        .y  (add_y),
        .c  (add_c),
        .z  (alu_z_unused),
        .n  (alu_n_unused),
        .v  (alu_v_unused)
    );

    // carry becomes the new MSB as the accumulator shifts right
    assign acc_nxt = {add_c, add_y, acc_lo_q[OPW-1:1]};
`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last  = (cnt_q == CNT_LAST) || (mult_q[OPW-1:1] == '0);
    assign p_fin = acc_nxt >> (CNT_LAST - cnt_q);
`else
    assign last  = cnt_q == CNT_LAST;
    assign p_fin = acc_nxt;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        hi_nz_d  = hi_nz_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                mcand_d  = a;
                mult_d   = b;
                acc_hi_d = '0;
                acc_lo_d = '0;
                cnt_d    = '0;
            end
            RUN: begin
                acc_hi_d = acc_nxt[2*OPW-1:OPW];
                acc_lo_d = acc_nxt[OPW-1:0];
                mult_d   = mult_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (last) begin
                    state_d = DONE;
                    p_d     = p_fin;
                    hi_nz_d = |p_fin[2*OPW-1:OPW];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            hi_nz_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            hi_nz_q  <= hi_nz_d;
        end
    end

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign p     = p_q;
    assign hi_nz = hi_nz_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vector table plus hand-written corner sequences for mul_seq
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, hi_nz;
    logic [15:0] a, b;
    logic [31:0] p;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        hi;
        int          lat;
        int          lat_ee;
    } vec_t;

    mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .hi_nz (hi_nz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [15:0] bv);
        int m;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        m = 1;
        for (int i = 0; i < 16; i++) if (bv[i]) m = i + 1;
        return m + 1;
`else
        m = bv[0];
        return 17 + m - m;
`endif
    endfunction

    task automatic run_op(input string name, input logic [15:0] ia, input logic [15:0] ib,
                          input logic [31:0] ep, input logic eh, input int el);
        int   k;
        logic busy_ok;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (!done && k < 40) begin
            busy_ok &= busy;
            @(negedge clk);
            k++;
        end
        chk({name, " latency"}, k, el);
        chk({name, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
        chk({name, " p"}, p, ep);
        chk({name, " hi_nz"}, {31'd0, hi_nz}, {31'd0, eh});
        @(negedge clk);
        chk({name, " done pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    vec_t vt[11];

    initial begin
        int k, dones;
        logic [15:0] ra, rb;
        logic [31:0] rp;
        vt[0]  = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0, 17, 4};
        vt[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 17, 17};
        vt[2]  = '{16'h1234, 16'h0001, 32'h00001234, 1'b0, 17, 2};
        vt[3]  = '{16'h1234, 16'h0000, 32'h00000000, 1'b0, 17, 2};
        vt[4]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0, 17, 2};
        vt[5]  = '{16'h0100, 16'h0100, 32'h00010000, 1'b1, 17, 10};
        vt[6]  = '{16'h8000, 16'h0002, 32'h00010000, 1'b1, 17, 3};
        vt[7]  = '{16'h1234, 16'h8000, 32'h091A0000, 1'b1, 17, 17};
        vt[8]  = '{16'h0000, 16'hABCD, 32'h00000000, 1'b0, 17, 17};
        vt[9]  = '{16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0, 17, 10};
        vt[10] = '{16'h0010, 16'h1000, 32'h00010000, 1'b1, 17, 14};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, hi_nz, p[28:0]}, 32'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p, vt[i].hi, vt[i].lat_ee);
`else
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p, vt[i].hi, vt[i].lat);
`endif
        end

        // result must stay put while idle with start low
        a = 16'h5555; b = 16'h5555;
        repeat (5) @(negedge clk);
        chk("idle hold p", p, 32'h00010000);
        chk("idle hold hi_nz", {31'd0, hi_nz}, 32'd1);

        // start held high, operands churning during the run
        @(negedge clk);
        a = 16'h0007; b = 16'h0009; start = 1'b1;
        @(negedge clk);
        k = 1;
        while (!done && k < 40) begin
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            k++;
        end
        chk("held start latency", k, lat_of(16'h0009));
        chk("held start p", p, 32'd63);
        a = 16'h0002; b = 16'h0003;
        @(negedge clk);
        chk("held start idle gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("held start relaunch", {31'd0, busy}, 32'd1);
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("relaunch p", p, 32'd6);
        @(negedge clk);

        // reset in the middle of a run
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-run reset", {busy, done, hi_nz, p[28:0]}, 32'd0);
        chk("mid-run reset p", p, 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            dones += int'(done) + int'(busy);
        end
        chk("no done after reset", dones, 0);

        // reset wins over a coincident start
        rst = 1'b1; start = 1'b1; a = 16'h0003; b = 16'h0003;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset beats start", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = (i % 7 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            rp = {16'd0, ra} * {16'd0, rb};
            @(negedge clk);
            a = ra; b = rb; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 1;
            dones = 0;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (done) dones++;
            @(negedge clk);
            if (done) dones++;
            if (p !== rp || hi_nz !== (rp > 32'hFFFF) || dones != 1 || k != lat_of(rb))
                chk($sformatf("rand%0d a=%h b=%h lat=%0d dones=%0d hi=%b", i, ra, rb, k, dones, hi_nz), p, rp);
            else
                total++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
